// File: rtl/mux16_rr_sched_pkg.sv
// Shared definitions for the round-robin mux scheduler.
//   N_REQ / SEL_W : requester count and mux-select width.
//   state_t       : scheduler FSM encoding.
//   rr_next       : round-robin search, from (ptr+1) mod N_REQ upward with
//                   wrap-around. ptr itself gets the lowest priority.
package mux16_rr_sched_pkg;

    localparam int N_REQ = 16;
    localparam int SEL_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Returns the first set bit of req found by walking upward from ptr+1.
    // The loop runs from the farthest offset to the nearest, so the nearest
    // set bit overwrites the result last and wins. Offset N_REQ wraps back
    // onto ptr itself. With req == 0 the result is ptr. Callers only use
    // the result when req != 0.
    function automatic logic [SEL_W-1:0] rr_next(
        input logic [N_REQ-1:0] req,
        input logic [SEL_W-1:0] ptr
    );
        logic [SEL_W-1:0] idx;
        rr_next = ptr;
        for (int j = N_REQ; j >= 1; j--) begin
            idx = ptr + SEL_W'(j);
            if (req[idx]) begin
                rr_next = idx;
            end
        end
    endfunction

endpackage

// File: rtl/mux16_rr_sched_mux16.sv
// Existing 16:1 bit-select mux datapath.
//   in  : 16 data bits
//   sel : 4-bit select
//   out : in[sel]
// Combinational. A decoded AND-OR tree: each leg is enabled by its own
// select decode.
module mux16
    import mux16_rr_sched_pkg::*;
(
    input  logic [N_REQ-1:0] in,
    input  logic [SEL_W-1:0] sel,
    output logic             out
);

    logic [N_REQ-1:0] leg;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_leg
        assign leg[gi] = (sel == SEL_W'(gi)) & in[gi];
    end

    assign out = |leg;

endmodule

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler in front of the shared mux16 datapath.
// Ports:
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset
//   req     : per-requester request vector
//   din     : per-requester data bits (mux inputs)
//   sel     : registered mux select = index of the current grantee
//   gnt     : registered one-hot grant; zero when idle
//   gnt_vld : registered; high while a grant is active
//   dout    : din[sel] while gnt_vld is high, otherwise 0 (combinational)
// Parameters:
//   MAX_HOLD : maximum tenure in cycles. 0 means release only on req drop.
//   HOLD_W   : tenure counter width. 2**HOLD_W must be >= MAX_HOLD.
module mux16_rr_sched
    import mux16_rr_sched_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] din,
    output logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_vld,
    output logic             dout
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;

    state_t            state_reg;
    logic [SEL_W-1:0]  sel_reg;
    logic [N_REQ-1:0]  gnt_reg;
    logic              gnt_vld_reg;
    logic [HOLD_W-1:0] hold_cnt_reg;
    logic [SEL_W-1:0]  ptr_reg;

    logic [SEL_W-1:0]  pick_next;
    logic              hold_done;
    logic              release_next;
    logic              mux_out;

    // The search starts just past the last released index. That index is
    // therefore the lowest priority, and a lone requester is still found
    // after the wrap.
    assign pick_next = rr_next(req, ptr_reg);

    assign hold_done    = (MAX_HOLD != 0) && (hold_cnt_reg == HOLD_LAST);
    assign release_next = !req[sel_reg] || hold_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            sel_reg      <= '0;
            gnt_reg      <= '0;
            gnt_vld_reg  <= 1'b0;
            hold_cnt_reg <= '0;
            ptr_reg      <= SEL_W'(N_REQ - 1);
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        sel_reg      <= pick_next;
                        gnt_reg      <= N_REQ'(1) << pick_next;
                        gnt_vld_reg  <= 1'b1;
                        hold_cnt_reg <= '0;
                        state_reg    <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_next) begin
                        // sel keeps its value. Going back through IDLE
                        // leaves a zero cycle on gnt between two grantees.
                        ptr_reg     <= sel_reg;
                        gnt_reg     <= '0;
                        gnt_vld_reg <= 1'b0;
                        state_reg   <= IDLE;
                    end else if (hold_cnt_reg != HOLD_SAT) begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    mux16 u_mux16 (
        .in  (din),
        .sel (sel_reg),
        .out (mux_out)
    );

    assign sel     = sel_reg;
    assign gnt     = gnt_reg;
    assign gnt_vld = gnt_vld_reg;
    assign dout    = gnt_vld_reg & mux_out;

endmodule

// File: tb/tb_mux16_rr_sched.sv
module tb_mux16_rr_sched;

    localparam int TB_HOLD = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic [15:0] req0;
    logic [15:0] din;

    logic [3:0]  sel,  sel0;
    logic [15:0] gnt,  gnt0;
    logic        gnt_vld, gnt_vld0;
    logic        dout, dout0;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: grantee index (-1 = idle), cycles held so far,
    // last released index, and the currently driven select.
    int m_g   = -1;
    int m_ten = 0;
    int m_ptr = 15;
    int m_sel = 0;

    mux16_rr_sched #(.MAX_HOLD(TB_HOLD), .HOLD_W(4)) dut (
        .clk(clk), .rst(rst), .req(req), .din(din),
        .sel(sel), .gnt(gnt), .gnt_vld(gnt_vld), .dout(dout)
    );

    mux16_rr_sched #(.MAX_HOLD(0), .HOLD_W(4)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .din(din),
        .sel(sel0), .gnt(gnt0), .gnt_vld(gnt_vld0), .dout(dout0)
    );

    always #5 clk = ~clk;

    wire [21:0] act = {gnt_vld, gnt, sel, dout};

    function automatic int rr_pick(logic [15:0] r, int p);
        for (int j = 1; j <= 16; j++) begin
            if (r[(p + j) % 16]) return (p + j) % 16;
        end
        return -1;
    endfunction

    function automatic void model_step();
        if (rst) begin
            m_g = -1; m_ten = 0; m_ptr = 15; m_sel = 0;
        end else if (m_g < 0) begin
            if (req != 16'h0) begin
                m_g = rr_pick(req, m_ptr);
                m_sel = m_g;
                m_ten = 1;
            end
        end else if (!req[m_g] || m_ten == TB_HOLD) begin
            m_ptr = m_g;
            m_g = -1;
        end else begin
            m_ten++;
        end
    endfunction

    function automatic logic [21:0] exp_vec();
        logic [15:0] g;
        logic v;
        v = (m_g >= 0);
        g = v ? (16'(1) << m_g) : 16'h0;
        return {v, g, 4'(m_sel), v ? din[m_sel] : 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [21:0] e;
        rst = 1'b1; req = 16'h0; din = 16'($urandom);
        tick(); tick();
        n_checks++;
        if (act !== 22'h0) begin
            n_fail++; $display("FAIL reset_state got=%h exp=%h", act, 22'h0);
        end
        rst = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            din = 16'($urandom);
            tick();
            e = exp_vec();
            n_checks++;
            if (act !== 22'h0 || act !== e) begin
                n_fail++; $display("FAIL idle_no_req cyc=%0d got=%h exp=%h", c, act, e);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_lone();
        logic [21:0] e;
        logic [15:0] eg;
        do_reset();
        req = 16'h0010; din = 16'h0010;
        for (int c = 1; c <= 30; c++) begin
            tick();
            e = exp_vec();
            n_checks++;
            if (act !== e) begin
                n_fail++; $display("FAIL lone_model cyc=%0d got=%h exp=%h", c, act, e);
            end
            if (c == 1 || c == 8 || c == 9 || c == 10) begin
                eg = (c == 9) ? 16'h0 : 16'h0010;
                n_checks++;
                if (gnt !== eg || (eg != 0 && (sel !== 4'd4 || dout !== 1'b1))) begin
                    n_fail++;
                    $display("FAIL lone_timing cyc=%0d gnt=%h sel=%0d dout=%b exp_gnt=%h", c, gnt, sel, dout, eg);
                end
            end
        end
        $display("test_lone done");
    endtask

    task automatic test_all();
        logic [21:0] e;
        logic prev_vld;
        int count;
        do_reset();
        req = 16'hFFFF; prev_vld = 1'b0; count = 0;
        for (int c = 1; c <= 17 * 9; c++) begin
            din = 16'($urandom);
            tick();
            e = exp_vec();
            n_checks++;
            if (act !== e) begin
                n_fail++; $display("FAIL all_model cyc=%0d got=%h exp=%h", c, act, e);
            end
            n_checks++;
            if ($countones(gnt) > 1) begin
                n_fail++; $display("FAIL all_onehot cyc=%0d gnt=%h exp=at most one bit", c, gnt);
            end
            if (gnt_vld && !prev_vld) begin
                n_checks++;
                if (sel !== 4'(count % 16)) begin
                    n_fail++; $display("FAIL all_order grant#%0d sel=%0d exp=%0d", count, sel, count % 16);
                end
                count++;
            end
            prev_vld = gnt_vld;
        end
        n_checks++;
        if (count != 17) begin
            n_fail++; $display("FAIL all_grant_count got=%0d exp=17", count);
        end
        $display("test_all done grants=%0d", count);
    endtask

    task automatic test_wrap();
        logic [21:0] e;
        do_reset();
        req = 16'h8001;
        for (int c = 1; c <= 25; c++) begin
            din = 16'($urandom);
            tick();
            e = exp_vec();
            n_checks++;
            if (act !== e) begin
                n_fail++; $display("FAIL wrap_model cyc=%0d got=%h exp=%h", c, act, e);
            end
            if (c == 1 || c == 4 || c == 5 || c == 14) begin
                n_checks++;
                if ((c == 4 && gnt_vld !== 1'b0) ||
                    (c == 1 && (gnt_vld !== 1'b1 || sel !== 4'd0)) ||
                    (c == 5 && (gnt_vld !== 1'b1 || sel !== 4'd15)) ||
                    (c == 14 && (gnt_vld !== 1'b1 || sel !== 4'd0))) begin
                    n_fail++; $display("FAIL wrap_order cyc=%0d vld=%b sel=%0d", c, gnt_vld, sel);
                end
            end
            if (c == 3) req = 16'h8000;
            if (c == 5) req = 16'h8001;
        end
        $display("test_wrap done");
    endtask

    task automatic test_rst_mid();
        logic [21:0] e;
        do_reset();
        req = 16'h0040; din = 16'h3f0a;
        tick(); tick(); tick();
        n_checks++;
        if (gnt !== 16'h0040 || sel !== 4'd6 || dout !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_pre gnt=%h sel=%0d dout=%b exp gnt=0040 sel=6 dout=0", gnt, sel, dout);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (act !== 22'h0) begin
            n_fail++; $display("FAIL rstmid_clear got=%h exp=%h", act, 22'h0);
        end
        rst = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            din = (c == 1) ? 16'h3f0a : 16'($urandom);
            tick();
            e = exp_vec();
            n_checks++;
            if (act !== e || (c == 1 && (gnt !== 16'h0040 || sel !== 4'd6))) begin
                n_fail++; $display("FAIL rstmid_regrant cyc=%0d got=%h exp=%h", c, act, e);
            end
        end
        $display("test_rst_mid done");
    endtask

    task automatic test_random();
        logic [21:0] e;
        do_reset();
        req = 16'($urandom);
        for (int c = 1; c <= 500; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 3))
                    0: req = 16'($urandom);
                    1: req = 16'(1) << $urandom_range(0, 15);
                    2: req = 16'h0;
                    default: req = 16'($urandom) & 16'($urandom) & 16'($urandom);
                endcase
            end
            rst = ($urandom_range(0, 60) == 0);
            din = 16'($urandom);
            tick();
            e = exp_vec();
            n_checks++;
            if (act !== e) begin
                n_fail++; $display("FAIL random_model cyc=%0d req=%h got=%h exp=%h", c, req, act, e);
            end
            din = 16'($urandom);
            #1;
            e = exp_vec();
            n_checks++;
            if (dout !== e[0]) begin
                n_fail++; $display("FAIL random_dout_comb cyc=%0d got=%b exp=%b", c, dout, e[0]);
            end
        end
        rst = 1'b0;
        $display("test_random done");
    endtask

    task automatic test_unlimited();
        req = 16'h0;
        do_reset();
        req0 = 16'h0200;
        for (int c = 1; c <= 40; c++) begin
            din = 16'($urandom);
            tick();
            n_checks++;
            if (gnt0 !== 16'h0200 || gnt_vld0 !== 1'b1 || sel0 !== 4'd9 || dout0 !== din[9]) begin
                n_fail++;
                $display("FAIL unlimited_hold cyc=%0d gnt=%h vld=%b sel=%0d dout=%b exp gnt=0200 vld=1 sel=9 dout=%b",
                         c, gnt0, gnt_vld0, sel0, dout0, din[9]);
            end
        end
        req0 = 16'h0;
        tick();
        n_checks++;
        if (gnt0 !== 16'h0 || gnt_vld0 !== 1'b0 || dout0 !== 1'b0) begin
            n_fail++; $display("FAIL unlimited_drop gnt=%h vld=%b dout=%b exp 0000/0/0", gnt0, gnt_vld0, dout0);
        end
        $display("test_unlimited done");
    endtask

    initial begin
        rst = 1'b1; req = 16'h0; req0 = 16'h0; din = 16'h0;
        test_reset();
        test_lone();
        test_all();
        test_wrap();
        test_rst_mid();
        test_random();
        test_unlimited();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
